// File: rtl/mem_ifm_pingpong.sv
// Purpose : double-buffered sparse IFM store; loader fills one bank while the PE array reads the other.
// Latency : write stored at the accepting edge; read data/sparsemap/nz count registered 1 cycle after an accepted request.
// Backpressure: wr_ready_o drops while the write bank is FULL (both banks full); reads only accepted from a FULL read bank.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   wr_valid_i/wr_ready_o         write beat handshake
//   wr_sparsemap_i                BUS_SIZE sparsemap bits per beat
//   wr_nonzero_data_i             BUS_SIZE bytes per beat
//   wr_bank_o                     bank currently being filled
//   rd_full_o                     read bank is FULL and readable
//   rd_req_i, rd_chunk_count_i,
//   rd_dat_count_i                read request and chunk/beat address
//   rd_valid_o, rd_sparsemap_o,
//   rd_nonzero_data_o, rd_nz_cnt_o registered read beat and its popcount
//   rd_release_i                  reader hands the bank back
//   rd_err_o                      one-cycle pulse on illegal request/release
module mem_ifm_pingpong #(
  parameter  int BUS_SIZE  = 32,
  parameter  int MEM_SIZE  = 128,
  parameter  int CHUNK_NUM = 8,
  localparam int DAT_CYC   = MEM_SIZE / BUS_SIZE,
  localparam int DW        = (DAT_CYC > 1) ? $clog2(DAT_CYC) : 1,
  localparam int CW        = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1,
  localparam int NW        = $clog2(BUS_SIZE + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [BUS_SIZE-1:0]   wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] wr_nonzero_data_i,
  output logic                  wr_bank_o,
  output logic                  rd_full_o,
  input  logic                  rd_req_i,
  input  logic [CW-1:0]         rd_chunk_count_i,
  input  logic [DW-1:0]         rd_dat_count_i,
  output logic                  rd_valid_o,
  output logic [BUS_SIZE-1:0]   rd_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] rd_nonzero_data_o,
  output logic [NW-1:0]         rd_nz_cnt_o,
  input  logic                  rd_release_i,
  output logic                  rd_err_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_t;

  localparam logic [DW-1:0] DAT_LAST   = DW'(DAT_CYC - 1);
  localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNK_NUM - 1);
  localparam logic [CW:0]   CHUNK_LIM  = (CW+1)'(CHUNK_NUM);
  localparam logic [DW:0]   DAT_LIM    = (DW+1)'(DAT_CYC);

  // Storage: one MEM_SIZE-wide word per chunk; a beat is a BUS_SIZE slice of it.
  logic [MEM_SIZE-1:0]   mem_sm [2][CHUNK_NUM];
  logic [MEM_SIZE*8-1:0] mem_nz [2][CHUNK_NUM];

  bank_state_t   bank_q [2];
  bank_state_t   bank_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [DW-1:0] dat_q, dat_d;

  logic wr_fire, wr_last, rd_accept, rel_ok;
  logic [BUS_SIZE-1:0]   sm_nxt;
  logic [BUS_SIZE*8-1:0] nz_dat_nxt;
  logic [NW-1:0]         nz_cnt_nxt;

  // Gated by reset so a mid-operation reset drops ready immediately.
  assign wr_ready_o = rst_ni & (bank_q[wr_bank_q] != FULL);
  assign rd_full_o  = (bank_q[rd_bank_q] == FULL);
  assign wr_bank_o  = wr_bank_q;

  assign wr_fire   = wr_valid_i & wr_ready_o;
  assign wr_last   = (chunk_q == CHUNK_LAST) & (dat_q == DAT_LAST);
  assign rd_accept = rd_req_i & rd_full_o &
                     ({1'b0, rd_chunk_count_i} < CHUNK_LIM) &
                     ({1'b0, rd_dat_count_i} < DAT_LIM);
  assign rel_ok    = rd_release_i & rd_full_o;

  // Bank ownership state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      chunk_q   <= '0;
      dat_q     <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      chunk_q   <= chunk_d;
      dat_q     <= dat_d;
    end
  end

  // Next state. The write bank is never FULL and a release only hits the FULL
  // read bank, so both updates touch different banks and can coexist.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    chunk_d   = chunk_q;
    dat_d     = dat_q;
    if (wr_fire) begin
      if (bank_q[wr_bank_q] == EMPTY) bank_d[wr_bank_q] = FILLING;
      if (wr_last) begin
        bank_d[wr_bank_q] = FULL;
        chunk_d           = '0;
        dat_d             = '0;
        wr_bank_d         = ~wr_bank_q;
      end else if (dat_q == DAT_LAST) begin
        dat_d   = '0;
        chunk_d = chunk_q + CW'(1);
      end else begin
        dat_d = dat_q + DW'(1);
      end
    end
    if (rel_ok) begin
      bank_d[rd_bank_q] = EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Memory write (not reset)
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_sm[wr_bank_q][chunk_q][BUS_SIZE*dat_q +: BUS_SIZE]     <= wr_sparsemap_i;
      mem_nz[wr_bank_q][chunk_q][BUS_SIZE*8*dat_q +: BUS_SIZE*8] <= wr_nonzero_data_i;
    end
  end

  // Read-side mux and popcount; only consumed when the address is in range.
  always_comb begin
    sm_nxt     = mem_sm[rd_bank_q][rd_chunk_count_i][BUS_SIZE*rd_dat_count_i +: BUS_SIZE];
    nz_dat_nxt = mem_nz[rd_bank_q][rd_chunk_count_i][BUS_SIZE*8*rd_dat_count_i +: BUS_SIZE*8];
    nz_cnt_nxt = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      nz_cnt_nxt = nz_cnt_nxt + NW'(sm_nxt[i]);
    end
  end

  // Registered read outputs; data holds when no request is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o        <= 1'b0;
      rd_err_o          <= 1'b0;
      rd_sparsemap_o    <= '0;
      rd_nonzero_data_o <= '0;
      rd_nz_cnt_o       <= '0;
    end else begin
      rd_valid_o <= rd_accept;
      rd_err_o   <= (rd_req_i & ~rd_accept) | (rd_release_i & ~rd_full_o);
      if (rd_accept) begin
        rd_sparsemap_o    <= sm_nxt;
        rd_nonzero_data_o <= nz_dat_nxt;
        rd_nz_cnt_o       <= nz_cnt_nxt;
      end
    end
  end

endmodule

// File: doc/mem_ifm_pingpong.md
Name: mem_ifm_pingpong

Overview:
- Double-buffered (ping-pong) sparse IFM store. Holds CHUNK_NUM chunks of MEM_SIZE sparsemap bits plus MEM_SIZE nonzero bytes per bank.
- The loader streams beats into one bank with a valid/ready handshake while the PE array reads the other bank by chunk/beat address. Banks swap on explicit release.
- Sits between the IFM DMA/loader and the PE-array sparse-data fetch. Adds flow control, bank ownership, registered reads and per-beat nonzero count.

Parameters:
- BUS_SIZE, 32, elements per beat (sparsemap bits and data bytes per transfer).
- MEM_SIZE, 128, elements per chunk; must be an integer multiple of BUS_SIZE.
- CHUNK_NUM, 8, chunks per bank (filter chunks plus output chunks).
- DAT_CYC (derived), MEM_SIZE/BUS_SIZE, beats per chunk.
- DW (derived), max(1,$clog2(DAT_CYC)).
- CW (derived), max(1,$clog2(CHUNK_NUM)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low. Synchronous deassert is provided externally.
- wr_valid_i  in  1  write beat valid.
- wr_ready_o  out  1  write bank can accept a beat.
- wr_sparsemap_i  in  BUS_SIZE  sparsemap beat.
- wr_nonzero_data_i  in  BUS_SIZE x 8  nonzero data beat.
- wr_bank_o  out  1  index of the bank currently being written.
- rd_full_o  out  1  read bank is full and readable.
- rd_req_i  in  1  read request.
- rd_chunk_count_i  in  CW  read chunk address.
- rd_dat_count_i  in  DW  read beat address within chunk.
- rd_valid_o  out  1  read data valid, 1 cycle after an accepted request.
- rd_sparsemap_o  out  BUS_SIZE  read sparsemap beat.
- rd_nonzero_data_o  out  BUS_SIZE x 8  read data beat.
- rd_nz_cnt_o  out  $clog2(BUS_SIZE+1)  popcount of rd_sparsemap_o.
- rd_release_i  in  1  reader is finished with the bank.
- rd_err_o  out  1  one-cycle pulse on an illegal read request or illegal release.

Behaviour:
Reset (rst_ni=0, async):
- Both banks EMPTY; wr_bank=0; rd_bank=0; internal write counters = 0.
- All outputs 0, except wr_ready_o=1 once reset deasserts.
- Memory arrays are not reset. A mid-operation reset discards a partial fill and any full bank.

Bank state (per bank, 2 bits): EMPTY -> FILLING -> FULL -> EMPTY.
- EMPTY -> FILLING: first accepted beat into the bank.
- FILLING -> FULL: the beat with chunk=CHUNK_NUM-1 and dat=DAT_CYC-1 is accepted.
- FULL -> EMPTY: rd_release_i while the bank is rd_bank and FULL.

Write side:
- wr_ready_o = (bank[wr_bank] != FULL).
- A beat is accepted when wr_valid_i & wr_ready_o. It is stored at [wr_bank][chunk_cnt][dat_cnt], element slice BUS_SIZE*dat_cnt +: BUS_SIZE.
- dat_cnt increments and wraps at DAT_CYC-1. On that wrap, chunk_cnt increments and wraps at CHUNK_NUM-1.
- On the final beat: the bank goes FULL, both counters go to 0, and wr_bank toggles in the same edge.
- wr_ready_o for the next beat then reflects the other bank. Back-to-back beats at 1/cycle run with no bubble while the other bank is EMPTY.
- Beats presented while wr_ready_o=0 are held by the source and are not written.

Read side:
- A request is accepted when rd_req_i & rd_full_o & chunk<CHUNK_NUM & dat<DAT_CYC, with rd_full_o = (bank[rd_bank]==FULL).
- Next cycle after an accepted request: rd_valid_o=1; data, sparsemap and nz_cnt are registered from that address.
- Output registers hold their last value when no request is accepted. rd_valid_o=0 in that case.
- rd_req_i with an out-of-range address or while rd_full_o=0: no read, rd_valid_o=0 next cycle, rd_err_o=1 next cycle.
- rd_release_i while rd_full_o=1: the bank goes EMPTY and rd_bank toggles at the edge.
- rd_release_i while rd_full_o=0: ignored, rd_err_o=1 next cycle.
- A request and a release in the same cycle: the read is served from the bank being released (data registered at that edge).

Simultaneous events:
- Final write beat into bank X and release of bank Y in the same cycle: both take effect.
- If both banks are FULL, wr_ready_o=0 until a release. wr_ready_o rises the cycle after the release edge.
- Writing and reading never target the same bank, because a FULL bank is never written.

Test Plan:
Settings: BUS_SIZE=4, MEM_SIZE=8 (DAT_CYC=2), CHUNK_NUM=3, so 6 beats per bank.
- Reset then fill: 6 beats, sparsemap=beat index, data=8'h10+index. After beat 6: rd_full_o=1, wr_bank_o=1, wr_ready_o=1.
- Registered read: read chunk=2, dat=1 -> next cycle rd_valid_o=1, sparsemap=4'h5, data bytes=8'h15, rd_nz_cnt_o=2.
- Back-pressure: fill bank 1 (12 beats total) with no release -> wr_ready_o=0 after beat 12. Beat 13 held. rd_release_i -> wr_ready_o=1 next cycle, rd_bank toggles to 1, beat 13 lands in bank 0 chunk 0 dat 0.
- Errors: rd_req with chunk=3, or with rd_full_o=0, or rd_release_i with rd_full_o=0 -> rd_err_o pulses one cycle, rd_valid_o=0, no state change.
- Concurrency: release bank 0 in the same cycle as the final beat of bank 1 -> bank 0 EMPTY, bank 1 FULL, rd_full_o stays 1, wr_ready_o=1.
- Async reset mid-fill after beat 3 (drop rst_ni off-edge) -> wr_ready_o=0 immediately and rd_full_o=0. After release, the next 6 beats fill bank 0 from chunk 0 dat 0.
